// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router control path: address width, the
// reserved destination code and the control FSM state encoding.
package router_pkg;

  localparam int ADDR_WIDTH = 2;

  // Destination code 3 has no FIFO behind it; such packets are dropped.
  localparam logic [ADDR_WIDTH-1:0] ADDR_INVALID = 2'b11;

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] LOAD_PARITY        = 3'd3;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd6;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

  // Select one of the three per-FIFO flags by destination address.
  // The invalid address selects nothing and yields 0.
  function automatic logic pick3(input logic [2:0] flags,
                                 input logic [ADDR_WIDTH-1:0] idx);
    case (idx)
      2'd0:    pick3 = flags[0];
      2'd1:    pick3 = flags[1];
      2'd2:    pick3 = flags[2];
      default: pick3 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router. Steers one packet at a time (header,
// payload, parity) into the FIFO chosen by the header address. All outputs
// are pure decodes of the registered state (Moore).
//
// Handshake: the source may present a new byte whenever busy is low; while
// busy is high it must hold data_in/pkt_valid unchanged. write_enb_reg is
// the FIFO write strobe for the byte on the bus in that cycle.
module router_fsm
  import router_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [ADDR_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  fifo_empty_0,
  input  logic                  fifo_empty_1,
  input  logic                  fifo_empty_2,
  input  logic                  soft_reset_0,
  input  logic                  soft_reset_1,
  input  logic                  soft_reset_2,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic [ADDR_WIDTH-1:0] fifo_sel,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  rst_int_reg,
  output logic                  write_enb_reg,
  output logic                  busy
);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fifo_sel_q, fifo_sel_d;
  logic [2:0]            empty_vec;
  logic [2:0]            soft_vec;
  logic                  sel_soft_reset;

  assign empty_vec      = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec       = {soft_reset_2, soft_reset_1, soft_reset_0};
  // Only the FIFO currently being loaded may abort the packet.
  assign sel_soft_reset = pick3(soft_vec, fifo_sel_q);

  // Next-state and next-destination logic; soft reset overrides all arcs.
  always_comb begin
    state_d    = state_q;
    fifo_sel_d = fifo_sel_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != ADDR_INVALID)) begin
          fifo_sel_d = data_in;
          state_d    = pick3(empty_vec, data_in) ? LOAD_FIRST_DATA
                                                 : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (pick3(empty_vec, fifo_sel_q)) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    if ((state_q != DECODE_ADDRESS) && sel_soft_reset) begin
      state_d = DECODE_ADDRESS;
    end
  end

  // State and destination registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DECODE_ADDRESS;
      fifo_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      fifo_sel_q <= fifo_sel_d;
    end
  end

  // Output decode straight from the registered state.
  always_comb begin
    fifo_sel      = fifo_sel_q;
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm. Outputs are packed into one vector
// {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
// and compared against hand-computed per-state patterns.
module tb_router_fsm;

  // Expected output patterns, one per state.
  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0010;
  localparam logic [7:0] O_LP   = 8'b0000_0011;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LAF  = 8'b0001_0011;
  localparam logic [7:0] O_WTE  = 8'b0000_0001;
  localparam logic [7:0] O_CPE  = 8'b0000_0101;

  logic       clk;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [1:0] fifo_sel;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;
  logic [7:0] outv;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  router_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .fifo_sel      (fifo_sel),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy)
  );

  assign outv = {detect_add, lfd_state, ld_state, laf_state,
                 full_state, rst_int_reg, write_enb_reg, busy};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Step once and compare outputs with the head of the expected queue.
  task automatic step_pop(input string tag);
    logic [7:0] e;
    step();
    e = exp_q.pop_front();
    chk(tag, outv, e);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;

    // Reset for two cycles
    step();
    step();
    chk("reset_outs", outv, O_DEC);
    chk("reset_sel", {6'd0, fifo_sel}, 8'd0);
    reset = 1'b0;

    // Basic load: address 1, 10 payload cycles, then parity
    pkt_valid = 1'b1;
    data_in   = 2'b01;
    exp_q.push_back(O_LFD);
    for (int i = 0; i < 10; i++) exp_q.push_back(O_LD);
    exp_q.push_back(O_LP);
    exp_q.push_back(O_CPE);
    exp_q.push_back(O_DEC);
    for (int i = 0; i < 14; i++) begin
      if (i == 11) pkt_valid = 1'b0;
      step_pop($sformatf("basic_c%0d", i + 1));
    end
    chk("basic_sel", {6'd0, fifo_sel}, 8'd1);

    // Wait for empty on FIFO 2
    pkt_valid    = 1'b1;
    data_in      = 2'b10;
    fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wait_c%0d", i), outv, O_WTE);
    end
    fifo_empty_2 = 1'b1;
    step();
    chk("wait_lfd", outv, O_LFD);
    chk("wait_sel", {6'd0, fifo_sel}, 8'd2);
    step();
    chk("wait_ld", outv, O_LD);

    // Back-pressure: full for 3 cycles, resume into LOAD_DATA
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("full_c%0d", i), outv, O_FULL);
    end
    fifo_full = 1'b0;
    step();
    chk("laf_1", outv, O_LAF);
    step();
    chk("laf_to_ld", outv, O_LD);

    // Back-pressure again, leaving via low_pkt_valid into LOAD_PARITY
    fifo_full = 1'b1;
    step();
    chk("full2", outv, O_FULL);
    fifo_full = 1'b0;
    step();
    chk("laf_2", outv, O_LAF);
    low_pkt_valid = 1'b1;
    pkt_valid     = 1'b0;
    step();
    chk("laf_to_lp", outv, O_LP);
    low_pkt_valid = 1'b0;
    fifo_full     = 1'b1;
    step();
    chk("lp_to_cpe", outv, O_CPE);
    step();
    chk("cpe_to_full", outv, O_FULL);
    fifo_full = 1'b0;
    step();
    chk("laf_3", outv, O_LAF);
    parity_done = 1'b1;
    step();
    chk("laf_parity_done", outv, O_DEC);
    parity_done = 1'b0;

    // Invalid address: dropped, fifo_sel stays 2
    pkt_valid = 1'b1;
    data_in   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("inv_c%0d", i), outv, O_DEC);
      chk($sformatf("inv_sel%0d", i), {6'd0, fifo_sel}, 8'd2);
    end

    // Soft reset in WAIT_TILL_EMPTY with fifo_sel=0
    data_in      = 2'b00;
    fifo_empty_0 = 1'b0;
    step();
    chk("sr_wte", outv, O_WTE);
    chk("sr_sel", {6'd0, fifo_sel}, 8'd0);
    pkt_valid    = 1'b0;
    soft_reset_1 = 1'b1;
    step();
    chk("sr_other_ignored", outv, O_WTE);
    soft_reset_1 = 1'b0;
    soft_reset_0 = 1'b1;
    step();
    chk("sr_selected", outv, O_DEC);
    soft_reset_0 = 1'b0;
    fifo_empty_0 = 1'b1;
    step();
    chk("idle_stay", outv, O_DEC);

    // Reset mid-packet
    pkt_valid = 1'b1;
    data_in   = 2'b01;
    step();
    chk("mid_lfd", outv, O_LFD);
    step();
    chk("mid_ld", outv, O_LD);
    reset = 1'b1;
    step();
    chk("mid_reset_outs", outv, O_DEC);
    chk("mid_reset_sel", {6'd0, fifo_sel}, 8'd0);
    reset     = 1'b0;
    pkt_valid = 1'b0;
    step();
    chk("post_reset_idle", outv, O_DEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM of the 1x3 router. It sequences one incoming packet at a time (header, payload, parity) into one of the three fifo_16x9_router instances.
- Decodes the destination address from the header byte and waits for the target FIFO to be empty before loading.
- Drives lfd_state and the write-enable strobe, handles FIFO-full back-pressure and the parity-check cycle.
- Sits between the input port and the synchroniser/register blocks. Its busy output back-pressures the source.

Parameters:
- ADDR_WIDTH, 2, width of the destination field data_in[1:0]. Value 3 is an invalid address.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pkt_valid  input  1  source asserts it from the header byte through the last payload byte.
- data_in  input  ADDR_WIDTH  destination field of the header byte; sampled only in DECODE_ADDRESS.
- fifo_full  input  1  full flag of the currently selected FIFO, muxed by the synchroniser.
- fifo_empty_0 / fifo_empty_1 / fifo_empty_2  input  1 each  empty flags of FIFO 0, 1 and 2.
- soft_reset_0 / soft_reset_1 / soft_reset_2  input  1 each  per-FIFO read-timeout soft resets.
- parity_done  input  1  register block has captured the parity byte.
- low_pkt_valid  input  1  pkt_valid fell while the FSM was in FIFO_FULL_STATE.
- fifo_sel  output  ADDR_WIDTH  latched destination address.
- detect_add  output  1  high in DECODE_ADDRESS.
- lfd_state  output  1  high in LOAD_FIRST_DATA (header byte is being written).
- ld_state  output  1  high in LOAD_DATA.
- laf_state  output  1  high in LOAD_AFTER_FULL.
- full_state  output  1  high in FIFO_FULL_STATE.
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  output  1  FIFO write strobe.
- busy  output  1  source must hold its data.

Behaviour:
- Outputs: all are registered-state decodes (Moore). No output depends combinationally on an input.
- Reset (reset=1 at a rising edge):
  - state goes to DECODE_ADDRESS; fifo_sel goes to 0.
  - detect_add=1; every other output is 0.
  - reset has priority over everything else.
- States, encoded in the package: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- DECODE_ADDRESS:
  - pkt_valid=1, data_in=k (k in 0..2) and fifo_empty_k=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in=k and fifo_empty_k=0 -> WAIT_TILL_EMPTY.
  - In both cases fifo_sel<=k.
  - data_in=3, or pkt_valid=0 -> stay; fifo_sel is unchanged. A packet with address 3 is dropped.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally. Dwell is exactly 1 cycle.
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE. This check has priority.
  - else pkt_valid=0 -> LOAD_PARITY.
  - else stay.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - else low_pkt_valid=1 -> LOAD_PARITY.
  - else -> LOAD_DATA.
- WAIT_TILL_EMPTY: fifo_empty_[fifo_sel]=1 -> LOAD_FIRST_DATA; else stay.
- Soft reset: soft_reset_[fifo_sel]=1 in any state other than DECODE_ADDRESS forces state to DECODE_ADDRESS next cycle.
  - This overrides the normal transition.
  - Soft resets of non-selected FIFOs are ignored.
- Output decode:
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Minimum packet latency: header seen in DECODE_ADDRESS -> lfd_state asserted 1 cycle later. A packet with N payload bytes returns to DECODE_ADDRESS N+4 cycles after the header cycle when there is no back-pressure.

Decomposition:
- Package router_pkg holds:
  - the state encoding as 3-bit localparams, in the order listed under Behaviour;
  - ADDR_WIDTH;
  - the invalid-address constant (2'b11).
- The block is a single module: a next-state combinational process, a state register, a fifo_sel register and an output decode. No sub-module.

Test Plan:
- Basic load: reset for 2 cycles, then pkt_valid=1, data_in=2'b01, fifo_empty_1=1, 10 payload cycles, pkt_valid=0.
  - Required: lfd_state high for 1 cycle; ld_state high for 10 cycles; LOAD_PARITY then CHECK_PARITY_ERROR (rst_int_reg=1 for 1 cycle); detect_add back high at cycle header+14.
- Wait for empty: data_in=2'b10, fifo_empty_2=0 for 5 cycles, then 1.
  - Required: busy=1 and write_enb_reg=0 for 5 cycles; lfd_state asserts the cycle after fifo_empty_2 rises; fifo_sel=2.
- Back-pressure: in LOAD_DATA raise fifo_full for 3 cycles.
  - Required: full_state=1 and write_enb_reg=0 for 3 cycles, then laf_state=1 for 1 cycle.
  - With low_pkt_valid=0 and parity_done=0 the FSM returns to LOAD_DATA; with low_pkt_valid=1 it goes to LOAD_PARITY.
- Soft reset: in WAIT_TILL_EMPTY with fifo_sel=0, pulse soft_reset_1 and then soft_reset_0.
  - Required: soft_reset_1 is ignored; soft_reset_0 gives detect_add=1 next cycle.
- Invalid address: pkt_valid=1, data_in=2'b11 for 4 cycles.
  - Required: stays in DECODE_ADDRESS; busy=0; fifo_sel unchanged.
- Reset mid-packet: assert reset during LOAD_DATA.
  - Required: next cycle detect_add=1, write_enb_reg=0, fifo_sel=0.
